fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 10 +
 rtl/fetch_queue_instr_fifo.sv | 48 ++++
 rtl/fetch_queue.sv | 62 ++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, depth and entry record for the fetch queue
package fetch_queue_pkg;
  localparam int XLEN_DEF = 32;
  localparam int DEPTH_DEF = 2;
  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc_plus_4;
  } entry_t;
endpackage

// File: rtl/fetch_queue_instr_fifo.sv
// instr_fifo: synchronous power-of-two fifo with flush and occupancy count
module instr_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = 3 * XLEN_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~flush;
    do_pop = pop & ~flush & (count_q != '0);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (!(do_push && !do_pop && count_q == (AW+1)'(DEPTH)));
  end
  assign dout = (count_q != '0) ? mem_q[rd_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction fetch queue between imem and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            fetch_stall,
  input  logic            decode_stall,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus_4_d
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  logic [CW:0] need;
  logic [3*XLEN-1:0] head;
  logic [2*XLEN-1:0] tag_q, tag_d;
  logic inflight_q, inflight_d, pop, accept, push;
  assign imem_addr = pc;
  assign valid_d = count != '0;
  assign {instr_d, pc_d, pc_plus_4_d} = head;
  always_comb begin
    pop = valid_d & ~decode_stall;
    need = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req = ~reset & ~flush & (need < (CW+1)'(DEPTH));
    accept = imem_req & imem_gnt;
    fetch_stall = ~accept & ~flush;
    push = inflight_q & ~flush;
    inflight_d = accept;
    tag_d = accept ? {pc, pc_plus_4} : tag_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      tag_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      tag_q <= tag_d;
    end
  end
  instr_fifo #(.DEPTH(DEPTH), .W(3 * XLEN)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({imem_rdata, tag_q}),
    .dout  (head),
    .count (count)
  );
endmodule
